// File: rtl/l2_port_arbiter.sv
// Request-port arbiter for the L2 cache: picks one of four L1-side sources,
// registers its request onto the L2 port, and returns a one-cycle ack on completion.
module l2_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 64,
    parameter int WB_MAX_WAIT = 15
) (
    input  logic                  clk_l2,
    input  logic                  rst_n,
    input  logic                  inst_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  data_req,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic                  dirty_req,
    input  logic [ADDR_WIDTH-1:0] dirty_addr,
    input  logic [LINE_WIDTH-1:0] dirty_wdata,
    input  logic                  wb_req,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [LINE_WIDTH-1:0] wb_wdata,
    input  logic                  full_flag,
    output logic                  inst_ack,
    output logic                  data_ack,
    output logic                  dirty_ack,
    output logic                  wb_ack,
    output logic                  l2_req,
    output logic                  l2_write,
    output logic [1:0]            l2_src,
    output logic [ADDR_WIDTH-1:0] l2_addr,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    input  logic                  l2_done,
    output logic                  busy
);

    localparam int WW = $clog2(WB_MAX_WAIT + 1);
    localparam logic [WW-1:0] WB_MAX = WW'(WB_MAX_WAIT);

    localparam logic [1:0] SRC_INST  = 2'd0;
    localparam logic [1:0] SRC_DATA  = 2'd1;
    localparam logic [1:0] SRC_DIRTY = 2'd2;
    localparam logic [1:0] SRC_WB    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            src_q, src_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic                  req_q, req_d;
    logic                  busy_q, busy_d;
    logic [3:0]            ack_q, ack_d;
    logic                  rr_data_last_q, rr_data_last_d;
    logic [WW-1:0]         wb_wait_q, wb_wait_d;

    logic                  any_req_s;
    logic                  wb_urgent_s;
    logic                  wb_granted_s;
    logic [1:0]            win_src_s;
    logic [ADDR_WIDTH-1:0] win_addr_s;
    logic [LINE_WIDTH-1:0] win_wdata_s;

    // Winner selection: dirty, then urgent wb, then inst/data round-robin, then wb.
    always_comb begin
        any_req_s   = inst_req | data_req | dirty_req | wb_req;
        wb_urgent_s = wb_req & (full_flag | (wb_wait_q == WB_MAX));
        if (dirty_req) begin
            win_src_s = SRC_DIRTY;
        end else if (wb_urgent_s) begin
            win_src_s = SRC_WB;
        end else if (inst_req && data_req) begin
            win_src_s = rr_data_last_q ? SRC_INST : SRC_DATA;
        end else if (inst_req) begin
            win_src_s = SRC_INST;
        end else if (data_req) begin
            win_src_s = SRC_DATA;
        end else if (wb_req) begin
            win_src_s = SRC_WB;
        end else begin
            win_src_s = SRC_INST;
        end
    end

    // Address / payload mux for the selected source; reads carry a zero payload.
    always_comb begin
        case (win_src_s)
            SRC_INST: begin
                win_addr_s  = inst_addr;
                win_wdata_s = {LINE_WIDTH{1'b0}};
            end
            SRC_DATA: begin
                win_addr_s  = data_addr;
                win_wdata_s = {LINE_WIDTH{1'b0}};
            end
            SRC_DIRTY: begin
                win_addr_s  = dirty_addr;
                win_wdata_s = dirty_wdata;
            end
            SRC_WB: begin
                win_addr_s  = wb_addr;
                win_wdata_s = wb_wdata;
            end
            default: begin
                win_addr_s  = {ADDR_WIDTH{1'b0}};
                win_wdata_s = {LINE_WIDTH{1'b0}};
            end
        endcase
    end

    // Write-buffer starvation counter; a wb transaction in flight counts as granted.
    always_comb begin
        if (state_q == ST_IDLE) begin
            wb_granted_s = any_req_s && (win_src_s == SRC_WB);
        end else begin
            wb_granted_s = (src_q == SRC_WB);
        end
        if (!wb_req || wb_granted_s) begin
            wb_wait_d = {WW{1'b0}};
        end else if (wb_wait_q != WB_MAX) begin
            wb_wait_d = wb_wait_q + WW'(1);
        end else begin
            wb_wait_d = wb_wait_q;
        end
    end

    // FSM next state; output registers are loaded from the transition itself.
    always_comb begin
        state_d        = state_q;
        src_d          = src_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        write_d        = write_q;
        req_d          = req_q;
        busy_d         = busy_q;
        ack_d          = 4'b0000;
        rr_data_last_d = rr_data_last_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_d = ST_BUSY;
                    src_d   = win_src_s;
                    addr_d  = win_addr_s;
                    wdata_d = win_wdata_s;
                    write_d = win_src_s[1];
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (l2_done) begin
                    state_d = ST_ACK;
                    req_d   = 1'b0;
                    ack_d   = 4'b0001 << src_q;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (!src_q[1]) begin
                    rr_data_last_d = src_q[0];
                end else begin
                    rr_data_last_d = rr_data_last_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; pointer resets to "data served last".
    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            src_q          <= 2'd0;
            addr_q         <= {ADDR_WIDTH{1'b0}};
            wdata_q        <= {LINE_WIDTH{1'b0}};
            write_q        <= 1'b0;
            req_q          <= 1'b0;
            busy_q         <= 1'b0;
            ack_q          <= 4'b0000;
            rr_data_last_q <= 1'b1;
            wb_wait_q      <= {WW{1'b0}};
        end else begin
            state_q        <= state_d;
            src_q          <= src_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            write_q        <= write_d;
            req_q          <= req_d;
            busy_q         <= busy_d;
            ack_q          <= ack_d;
            rr_data_last_q <= rr_data_last_d;
            wb_wait_q      <= wb_wait_d;
        end
    end

    assign l2_req    = req_q;
    assign l2_write  = write_q;
    assign l2_src    = src_q;
    assign l2_addr   = addr_q;
    assign l2_wdata  = wdata_q;
    assign busy      = busy_q;
    assign inst_ack  = ack_q[0];
    assign data_ack  = ack_q[1];
    assign dirty_ack = ack_q[2];
    assign wb_ack    = ack_q[3];

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: each task drives one scenario and checks
// cycle-exact outputs against hand-derived expectations.
module tb_l2_port_arbiter;

    logic        clk_l2 = 1'b0;
    logic        rst_n  = 1'b0;
    logic        inst_req = 1'b0, data_req = 1'b0, dirty_req = 1'b0, wb_req = 1'b0;
    logic [31:0] inst_addr = 32'h0, data_addr = 32'h0, dirty_addr = 32'h0, wb_addr = 32'h0;
    logic [63:0] dirty_wdata = 64'h0, wb_wdata = 64'h0;
    logic        full_flag = 1'b0, l2_done = 1'b0;
    logic        inst_ack, data_ack, dirty_ack, wb_ack;
    logic        l2_req, l2_write, busy;
    logic [1:0]  l2_src;
    logic [31:0] l2_addr;
    logic [63:0] l2_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] gsrc [16];
    int         gcyc [16];
    int         ng;

    l2_port_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(64), .WB_MAX_WAIT(15)) dut (
        .clk_l2(clk_l2), .rst_n(rst_n),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .data_req(data_req), .data_addr(data_addr),
        .dirty_req(dirty_req), .dirty_addr(dirty_addr), .dirty_wdata(dirty_wdata),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
        .full_flag(full_flag),
        .inst_ack(inst_ack), .data_ack(data_ack), .dirty_ack(dirty_ack), .wb_ack(wb_ack),
        .l2_req(l2_req), .l2_write(l2_write), .l2_src(l2_src),
        .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_done(l2_done), .busy(busy)
    );

    always #5 clk_l2 = ~clk_l2;

    task automatic step();
        @(posedge clk_l2);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req = 1'b0; data_req = 1'b0; dirty_req = 1'b0; wb_req = 1'b0;
        full_flag = 1'b0; l2_done = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk_l2);
        #1 rst_n = 1'b1;
    endtask

    // Requesters that hold req until ack and drop it for one cycle afterwards; L2 completes immediately.
    task automatic run_sat(input bit wb_en, input int wb_start, input bit use_full, input int ncyc);
        logic p_inst_ack, p_data_ack, p_wb_ack, p_req, wb_gone;
        p_inst_ack = 1'b0; p_data_ack = 1'b0; p_wb_ack = 1'b0; p_req = 1'b0; wb_gone = 1'b0;
        ng = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (l2_req && !p_req && ng < 16) begin
                gsrc[ng] = l2_src;
                gcyc[ng] = k;
                ng++;
            end
            if (p_wb_ack) wb_gone = 1'b1;
            inst_req  = !p_inst_ack;
            data_req  = !p_data_ack;
            wb_req    = wb_en && (k >= wb_start) && !wb_gone;
            full_flag = use_full && wb_req;
            l2_done   = l2_req;
            p_inst_ack = inst_ack; p_data_ack = data_ack; p_wb_ack = wb_ack; p_req = l2_req;
            step();
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++; if ({l2_req, l2_write, l2_src, busy, inst_ack, data_ack, dirty_ack, wb_ack} !== 9'b0)
            begin n_fail++; $display("FAIL reset_ctrl got %b exp 0", {l2_req, l2_write, l2_src, busy, inst_ack, data_ack, dirty_ack, wb_ack}); end
        n_checks++; if (l2_addr !== 32'h0 || l2_wdata !== 64'h0)
            begin n_fail++; $display("FAIL reset_data got %h/%h exp 0/0", l2_addr, l2_wdata); end
    endtask

    task automatic test_single_inst();
        reset_dut();
        inst_addr = 32'h0004_0010; inst_req = 1'b1;
        n_checks++; if (l2_req !== 1'b0) begin n_fail++; $display("FAIL single_c0_req got %b exp 0", l2_req); end
        step();
        n_checks++; if (l2_req !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL single_c1_req got %b/%b exp 1/1", l2_req, busy); end
        n_checks++; if (l2_src !== 2'd0 || l2_write !== 1'b0) begin n_fail++; $display("FAIL single_c1_src got %0d/%b exp 0/0", l2_src, l2_write); end
        n_checks++; if (l2_addr !== 32'h0004_0010 || l2_wdata !== 64'h0) begin n_fail++; $display("FAIL single_c1_addr got %h/%h exp 00040010/0", l2_addr, l2_wdata); end
        step();
        n_checks++; if (l2_req !== 1'b1 || inst_ack !== 1'b0) begin n_fail++; $display("FAIL single_c2_hold got %b/%b exp 1/0", l2_req, inst_ack); end
        l2_done = 1'b1;
        step();
        l2_done = 1'b0;
        n_checks++; if ({l2_req, inst_ack, data_ack, dirty_ack, wb_ack, busy} !== 6'b010001)
            begin n_fail++; $display("FAIL single_c3_ack got %b exp 010001", {l2_req, inst_ack, data_ack, dirty_ack, wb_ack, busy}); end
        step();
        inst_req = 1'b0;
        n_checks++; if (inst_ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_c4_idle got %b/%b exp 0/0", inst_ack, busy); end
        step();
        n_checks++; if (l2_req !== 1'b0) begin n_fail++; $display("FAIL single_no_regrant got %b exp 0", l2_req); end
    endtask

    task automatic test_dirty_first();
        reset_dut();
        dirty_addr = 32'h40; dirty_wdata = 64'h567; data_addr = 32'h80;
        dirty_req = 1'b1; data_req = 1'b1;
        step();
        n_checks++; if (l2_src !== 2'd2 || l2_write !== 1'b1) begin n_fail++; $display("FAIL dirty_src got %0d/%b exp 2/1", l2_src, l2_write); end
        n_checks++; if (l2_addr !== 32'h40 || l2_wdata !== 64'h567) begin n_fail++; $display("FAIL dirty_data got %h/%h exp 40/567", l2_addr, l2_wdata); end
        l2_done = 1'b1;
        step();
        l2_done = 1'b0;
        n_checks++; if (dirty_ack !== 1'b1 || data_ack !== 1'b0) begin n_fail++; $display("FAIL dirty_ack got %b/%b exp 1/0", dirty_ack, data_ack); end
        step();
        dirty_req = 1'b0;
        step();
        n_checks++; if (l2_req !== 1'b1 || l2_src !== 2'd1 || l2_write !== 1'b0) begin n_fail++; $display("FAIL data_after got %b/%0d/%b exp 1/1/0", l2_req, l2_src, l2_write); end
        n_checks++; if (l2_addr !== 32'h80 || l2_wdata !== 64'h0) begin n_fail++; $display("FAIL data_after_data got %h/%h exp 80/0", l2_addr, l2_wdata); end
        l2_done = 1'b1;
        step();
        l2_done = 1'b0;
        n_checks++; if (data_ack !== 1'b1) begin n_fail++; $display("FAIL data_ack got %b exp 1", data_ack); end
        step();
        data_req = 1'b0;
    endtask

    task automatic test_all_four();
        reset_dut();
        wb_addr = 32'hC0; wb_wdata = 64'h99;
        inst_req = 1'b1; data_req = 1'b1; dirty_req = 1'b1; wb_req = 1'b1;
        step();
        n_checks++; if (l2_src !== 2'd2) begin n_fail++; $display("FAIL all_four_src got %0d exp 2", l2_src); end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        run_sat(1'b0, 0, 1'b0, 12);
        n_checks++; if (ng !== 4) begin n_fail++; $display("FAIL rr_count got %0d exp 4", ng); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= ng || gsrc[i] !== 2'(i % 2) || gcyc[i] !== 1 + 3 * i) begin
                n_fail++; $display("FAIL rr_grant%0d got src %0d cyc %0d exp src %0d cyc %0d", i, gsrc[i], gcyc[i], i % 2, 1 + 3 * i);
            end
        end
    endtask

    task automatic test_wb_promote();
        logic [1:0] exp_src [6];
        exp_src = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd3};
        reset_dut();
        run_sat(1'b1, 0, 1'b0, 20);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= ng || gsrc[i] !== exp_src[i] || gcyc[i] !== 1 + 3 * i) begin
                n_fail++; $display("FAIL wb_wait_grant%0d got src %0d cyc %0d exp src %0d cyc %0d", i, gsrc[i], gcyc[i], exp_src[i], 1 + 3 * i);
            end
        end
    endtask

    task automatic test_wb_full();
        logic [1:0] exp_src [3];
        exp_src = '{2'd0, 2'd3, 2'd1};
        reset_dut();
        run_sat(1'b1, 1, 1'b1, 12);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= ng || gsrc[i] !== exp_src[i] || gcyc[i] !== 1 + 3 * i) begin
                n_fail++; $display("FAIL wb_full_grant%0d got src %0d cyc %0d exp src %0d cyc %0d", i, gsrc[i], gcyc[i], exp_src[i], 1 + 3 * i);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        reset_dut();
        inst_addr = 32'h1000; data_addr = 32'h2000;
        inst_req = 1'b1;
        step();
        l2_done = 1'b1;
        step();
        l2_done = 1'b0;
        step();
        inst_req = 1'b0; data_req = 1'b1;
        step();
        n_checks++; if (l2_req !== 1'b1 || l2_src !== 2'd1) begin n_fail++; $display("FAIL rst_pre got %b/%0d exp 1/1", l2_req, l2_src); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({l2_req, l2_write, l2_src, busy, inst_ack, data_ack, dirty_ack, wb_ack} !== 9'b0 || l2_addr !== 32'h0 || l2_wdata !== 64'h0)
            begin n_fail++; $display("FAIL rst_async got %b addr %h exp 0", {l2_req, l2_write, l2_src, busy}, l2_addr); end
        inst_req = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        n_checks++; if (l2_req !== 1'b1 || l2_src !== 2'd0 || l2_addr !== 32'h1000)
            begin n_fail++; $display("FAIL rst_rearb got %b/%0d/%h exp 1/0/1000", l2_req, l2_src, l2_addr); end
        clear_inputs();
    endtask

    task automatic test_drop_mid_busy();
        int acks;
        reset_dut();
        data_addr = 32'h3000;
        data_req = 1'b1;
        step();
        data_req = 1'b0;
        acks = 0;
        for (int k = 1; k < 8; k++) begin
            if (data_ack) acks++;
            l2_done = (k == 3);
            if (k == 3) begin
                n_checks++; if (l2_req !== 1'b1 || l2_addr !== 32'h3000) begin n_fail++; $display("FAIL drop_hold got %b/%h exp 1/3000", l2_req, l2_addr); end
            end
            step();
        end
        l2_done = 1'b0;
        n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL drop_ack_count got %0d exp 1", acks); end
        n_checks++; if (l2_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle got %b/%b exp 0/0", l2_req, busy); end
    endtask

    initial begin
        test_reset();
        test_single_inst();
        test_dirty_first();
        test_all_four();
        test_back_to_back();
        test_wb_promote();
        test_wb_full();
        test_reset_mid_busy();
        test_drop_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_port_arbiter.md
# l2_port_arbiter

Sequencing arbiter for the single request port of the L2 cache. It takes four L1-side requesters: IL1 line update, DL1 line update, DL1 dirty-line writeback, and DL1 write-buffer drain. It selects one, muxes its address, opcode and write payload onto the L2 port, and holds the grant until L2 reports completion. It then returns a one-cycle acknowledge to the winner. The block sits between IL1_Cache/DL1_Cache and L2_Cache in the clk_l2 domain.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width of every request
- LINE_WIDTH, 64, write payload width (dirty line / write-buffer entry)
- WB_MAX_WAIT, 15, cycles the write buffer may be bypassed before it is promoted

Ports:
- clk_l2  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- inst_req  in  1  IL1 update request, level, held until inst_ack
- inst_addr  in  ADDR_WIDTH  IL1 miss address
- data_req  in  1  DL1 update request, level
- data_addr  in  ADDR_WIDTH  DL1 miss address
- dirty_req  in  1  DL1 dirty writeback request, level
- dirty_addr  in  ADDR_WIDTH  victim line address
- dirty_wdata  in  LINE_WIDTH  victim data
- wb_req  in  1  write-buffer drain request, level
- wb_addr  in  ADDR_WIDTH  write-buffer entry address
- wb_wdata  in  LINE_WIDTH  write-buffer entry data
- full_flag  in  1  write buffer full
- inst_ack, data_ack, dirty_ack, wb_ack  out  1 each  one-cycle completion pulse to the granted source
- l2_req  out  1  request valid to L2
- l2_write  out  1  1 = write (dirty/wb), 0 = read (inst/data)
- l2_src  out  2  source id: 0 inst, 1 data, 2 dirty, 3 wb
- l2_addr  out  ADDR_WIDTH  muxed address
- l2_wdata  out  LINE_WIDTH  muxed write data; 0 for reads
- l2_done  in  1  L2 completion, sampled only while l2_req=1
- busy  out  1  arbiter not IDLE

## Operation
- State machine: IDLE -> BUSY -> ACK -> IDLE.
- IDLE: if any request is high, the arbiter picks a winner and registers l2_src, l2_addr, l2_wdata and l2_write. It then moves to BUSY. With no request, it stays in IDLE.
- Winner priority, highest first:
  1. dirty_req. A writeback always precedes the DL1 refill it frees space for.
  2. wb_req, when full_flag=1 or wb_wait==WB_MAX_WAIT.
  3. inst_req/data_req, round-robin. If both are high, the source not served last wins. After reset, last-served = data, so inst wins first.
  4. wb_req otherwise.
- BUSY: l2_req=1. Outputs stay frozen until l2_done=1. On l2_done=1, the FSM moves to ACK.
- ACK: l2_req=0. Exactly one of the *_ack outputs is high, selected by l2_src. The FSM returns to IDLE on the next edge.
- Requester deasserting its req during BUSY is ignored. The transaction completes and the ack is still pulsed.
- Round-robin pointer: updates only in ACK, and only when l2_src is 0 or 1.
- wb_wait counter, width $clog2(WB_MAX_WAIT+1):
  - increments each cycle that wb_req=1 and the wb source is not granted;
  - saturates at WB_MAX_WAIT;
  - clears when wb is granted or when wb_req=0.
- Requests arriving during BUSY/ACK wait. They are evaluated in the next IDLE cycle.
- Reset (asynchronous, any state):
  - FSM returns to IDLE;
  - l2_req, l2_write, l2_src, l2_addr, l2_wdata, all *_ack and busy go to 0;
  - wb_wait clears to 0;
  - round-robin pointer resets to "data last".
  - An in-flight L2 transaction is abandoned; L2 shares rst_n.

## Timing
- Requester protocol: the requester holds req high until it sees its ack. It must drop req in the cycle after the ack, so the next IDLE sample does not re-grant it.
- Grant latency: req first high in IDLE cycle n gives l2_req=1 in cycle n+1.
- Completion: l2_done=1 in cycle m gives ack=1 in cycle m+1, and IDLE in cycle m+2.
- Minimum transaction: l2_done in the first BUSY cycle takes 3 cycles (BUSY, ACK, IDLE). The next grant's l2_req rises in cycle m+3.
- busy=1 exactly in BUSY and ACK cycles.
- l2_addr, l2_wdata, l2_src and l2_write are registered. They are stable for the whole BUSY interval and remain valid through ACK.
- Simultaneous events:
  - all four requests high in the same IDLE cycle, full_flag=0, wb_wait<max: dirty wins.
  - ack and a new req from a different source in the same cycle: the new req is sampled in the following IDLE cycle.

## Test plan
- Single inst_req, inst_addr=32'h0004_0010, l2_done 2 cycles after l2_req -> l2_req high for 2 cycles, l2_src=0, l2_write=0, inst_ack one cycle, busy drops in the next cycle.
- dirty_req (addr 32'h40, wdata 64'h567) and data_req (addr 32'h80) raised together -> dirty served first with l2_write=1 and l2_wdata=64'h567, then data with l2_src=1 and l2_wdata=0.
- inst_req and data_req held continuously (re-raised after each ack), l2_done immediate -> grants alternate inst, data, inst, data.
- inst/data saturating the port, wb_req high, full_flag=0, WB_MAX_WAIT=15 -> wb granted on the first IDLE after wb_wait reaches 15. Repeat with full_flag=1 -> wb granted at the next IDLE, ahead of inst/data.
- rst_n pulled low mid-BUSY -> all outputs 0 immediately. After release, the FSM re-arbitrates from IDLE with inst favored.
- Requester drops req mid-BUSY -> transaction still completes and the ack is still pulsed once.
